// File: rtl/vga_rx_capture.sv
// Receive-side VGA capture: rebuilds raster position from incoming syncs, checks frame timing
// against the expected format, and streams RGB565 pixels with coordinates once locked.
module vga_rx_capture #(
  parameter int unsigned H_SYNC      = 44,
  parameter int unsigned H_BACK      = 148,
  parameter int unsigned H_VALID     = 1920,
  parameter int unsigned H_TOTAL     = 2200,
  parameter int unsigned V_SYNC      = 5,
  parameter int unsigned V_BACK      = 36,
  parameter int unsigned V_VALID     = 1080,
  parameter int unsigned V_TOTAL     = 1125,
  parameter int unsigned LOCK_FRAMES = 2
) (
  input  logic        vga_clk_i,
  input  logic        sys_rst_i,
  input  logic        hsync_i,
  input  logic        vsync_i,
  input  logic [7:0]  rgb_r_i,
  input  logic [7:0]  rgb_g_i,
  input  logic [7:0]  rgb_b_i,
  output logic        pix_valid_o,
  output logic [11:0] pix_x_o,
  output logic [11:0] pix_y_o,
  output logic [15:0] pix_data_o,
  output logic        frame_start_o,
  output logic        locked_o,
  output logic [11:0] meas_h_total_o,
  output logic [11:0] meas_v_total_o
);

  localparam int unsigned HActLo = H_SYNC + H_BACK;
  localparam int unsigned HActHi = H_SYNC + H_BACK + H_VALID;
  localparam int unsigned VActLo = V_SYNC + V_BACK;
  localparam int unsigned VActHi = V_SYNC + V_BACK + V_VALID;
  localparam int unsigned GoodW  = (LOCK_FRAMES < 2) ? 1 : $clog2(LOCK_FRAMES + 1);
  localparam logic [11:0] CntMax = 12'hFFF;

  typedef enum logic [1:0] {StUnlocked, StLocking, StLocked} lock_state_e;

  // Input stage S1; only the bits that survive RGB565 packing are kept
  logic        hs_s1_q, vs_s1_q, hs_d_q;
  logic [15:0] rgb_s1_q;
  logic        unused_rgb;
  assign unused_rgb = ^{rgb_r_i[2:0], rgb_g_i[1:0], rgb_b_i[2:0]};

  logic [11:0] h_cnt_q, h_cnt_d, v_cnt_q, v_cnt_d;
  logic [11:0] meas_h_q, meas_h_d, meas_v_q, meas_v_d;
  logic        seen_hs_q, seen_hs_d, seen_vs_q, seen_vs_d;
  logic        line_err_q, line_err_d, vs_line_prev_q, vs_line_prev_d;

  lock_state_e      state_q;
  logic [GoodW-1:0] good_cnt_q;
  logic             locked_q;

  logic        pix_valid_q, frame_start_q;
  logic [11:0] pix_x_q, pix_y_q;
  logic [15:0] pix_data_q;

  logic        hs_rise, vs_rise, line_bad, frame_eval, frame_good;
  logic        h_active, v_active, px_valid_d;
  logic [12:0] h_len, v_len;
  logic [11:0] px_x_d, px_y_d;

  assign hs_rise    = hs_s1_q & ~hs_d_q;
  assign vs_rise    = vs_s1_q & ~vs_line_prev_q;
  // 13-bit lengths so a saturated counter never aliases a legal total
  assign h_len      = {1'b0, h_cnt_q} + 13'd1;
  assign v_len      = {1'b0, v_cnt_q} + 13'd1;
  assign line_bad   = seen_hs_q & ((h_len != 13'(H_TOTAL)) | (h_cnt_q == CntMax));
  assign frame_eval = hs_rise & vs_rise & seen_vs_q;
  assign frame_good = (v_len == 13'(V_TOTAL)) & ~line_err_q & ~line_bad;

  assign h_active   = (32'(h_cnt_q) >= HActLo) && (32'(h_cnt_q) < HActHi);
  assign v_active   = (32'(v_cnt_q) >= VActLo) && (32'(v_cnt_q) < VActHi);
  assign px_valid_d = h_active & v_active & locked_q;
  assign px_x_d     = px_valid_d ? h_cnt_q - 12'(HActLo) : 12'd0;
  assign px_y_d     = px_valid_d ? v_cnt_q - 12'(VActLo) : 12'd0;

  always_comb begin
    h_cnt_d        = hs_rise ? 12'd0 : ((h_cnt_q == CntMax) ? h_cnt_q : h_cnt_q + 12'd1);
    v_cnt_d        = v_cnt_q;
    meas_h_d       = meas_h_q;
    meas_v_d       = meas_v_q;
    seen_hs_d      = seen_hs_q;
    seen_vs_d      = seen_vs_q;
    line_err_d     = line_err_q;
    vs_line_prev_d = vs_line_prev_q;
    if (hs_rise) begin
      seen_hs_d      = 1'b1;
      vs_line_prev_d = vs_s1_q;
      // A saturated line measures 4096, which wraps to 0 in the 12-bit report
      if (seen_hs_q) meas_h_d = h_len[11:0];
      if (vs_rise) begin
        v_cnt_d    = 12'd0;
        seen_vs_d  = 1'b1;
        line_err_d = 1'b0;
        if (seen_vs_q) meas_v_d = v_len[11:0];
      end else begin
        if (v_cnt_q != CntMax) v_cnt_d = v_cnt_q + 12'd1;
        if (line_bad) line_err_d = 1'b1;
      end
    end
  end

  always_ff @(posedge vga_clk_i or posedge sys_rst_i) begin
    if (sys_rst_i) begin
      hs_s1_q        <= 1'b0;
      vs_s1_q        <= 1'b0;
      hs_d_q         <= 1'b0;
      rgb_s1_q       <= 16'd0;
      h_cnt_q        <= 12'd0;
      v_cnt_q        <= 12'd0;
      meas_h_q       <= 12'd0;
      meas_v_q       <= 12'd0;
      seen_hs_q      <= 1'b0;
      seen_vs_q      <= 1'b0;
      line_err_q     <= 1'b0;
      vs_line_prev_q <= 1'b0;
    end else begin
      hs_s1_q        <= hsync_i;
      vs_s1_q        <= vsync_i;
      hs_d_q         <= hs_s1_q;
      rgb_s1_q       <= {rgb_r_i[7:3], rgb_g_i[7:2], rgb_b_i[7:3]};
      h_cnt_q        <= h_cnt_d;
      v_cnt_q        <= v_cnt_d;
      meas_h_q       <= meas_h_d;
      meas_v_q       <= meas_v_d;
      seen_hs_q      <= seen_hs_d;
      seen_vs_q      <= seen_vs_d;
      line_err_q     <= line_err_d;
      vs_line_prev_q <= vs_line_prev_d;
    end
  end

  // Lock FSM: advances only at frame evaluation, but a bad line drops lock at once
  always_ff @(posedge vga_clk_i or posedge sys_rst_i) begin
    if (sys_rst_i) begin
      state_q    <= StUnlocked;
      good_cnt_q <= '0;
      locked_q   <= 1'b0;
    end else if (frame_eval) begin
      unique case (state_q)
        StUnlocked: begin
          if (frame_good) begin
            if (LOCK_FRAMES <= 1) begin
              state_q  <= StLocked;
              locked_q <= 1'b1;
            end else begin
              state_q    <= StLocking;
              good_cnt_q <= GoodW'(1);
            end
          end
        end
        StLocking: begin
          if (!frame_good) begin
            state_q    <= StUnlocked;
            good_cnt_q <= '0;
          end else if (32'(good_cnt_q) + 32'd1 >= LOCK_FRAMES) begin
            state_q    <= StLocked;
            locked_q   <= 1'b1;
            good_cnt_q <= '0;
          end else begin
            good_cnt_q <= good_cnt_q + GoodW'(1);
          end
        end
        StLocked: begin
          if (!frame_good) begin
            state_q  <= StUnlocked;
            locked_q <= 1'b0;
          end
        end
        default: begin
          state_q    <= StUnlocked;
          locked_q   <= 1'b0;
          good_cnt_q <= '0;
        end
      endcase
    end else if (hs_rise && line_bad && state_q == StLocked) begin
      state_q  <= StUnlocked;
      locked_q <= 1'b0;
    end
  end

  always_ff @(posedge vga_clk_i or posedge sys_rst_i) begin
    if (sys_rst_i) begin
      pix_valid_q   <= 1'b0;
      pix_x_q       <= 12'd0;
      pix_y_q       <= 12'd0;
      pix_data_q    <= 16'd0;
      frame_start_q <= 1'b0;
    end else begin
      pix_valid_q   <= px_valid_d;
      pix_x_q       <= px_x_d;
      pix_y_q       <= px_y_d;
      pix_data_q    <= px_valid_d ? rgb_s1_q : 16'd0;
      frame_start_q <= px_valid_d & (px_x_d == 12'd0) & (px_y_d == 12'd0);
    end
  end

  assign pix_valid_o    = pix_valid_q;
  assign pix_x_o        = pix_x_q;
  assign pix_y_o        = pix_y_q;
  assign pix_data_o     = pix_data_q;
  assign frame_start_o  = frame_start_q;
  assign locked_o       = locked_q;
  assign meas_h_total_o = meas_h_q;
  assign meas_v_total_o = meas_v_q;

endmodule

// File: tb/tb_vga_rx_capture.sv
// Directed bench for vga_rx_capture: small-format loopback generator, lock/drop/relock
// scenarios, ramp pixel checks against the driven pins, and asynchronous reset.
module tb_vga_rx_capture;
  localparam int HS = 2, HB = 3, HV = 8, HT = 16;
  localparam int VS = 1, VB = 2, VV = 4, VT = 10;

  logic        clk = 1'b0, rst = 1'b1;
  logic        hsync = 1'b0, vsync = 1'b0;
  logic [7:0]  r = 8'd0, g = 8'd0, b = 8'd0;
  logic        pix_valid, frame_start, locked;
  logic [11:0] pix_x, pix_y, meas_h, meas_v;
  logic [15:0] pix_data;

  vga_rx_capture #(
    .H_SYNC(HS), .H_BACK(HB), .H_VALID(HV), .H_TOTAL(HT),
    .V_SYNC(VS), .V_BACK(VB), .V_VALID(VV), .V_TOTAL(VT), .LOCK_FRAMES(2)
  ) dut (
    .vga_clk_i     (clk),
    .sys_rst_i     (rst),
    .hsync_i       (hsync),
    .vsync_i       (vsync),
    .rgb_r_i       (r),
    .rgb_g_i       (g),
    .rgb_b_i       (b),
    .pix_valid_o   (pix_valid),
    .pix_x_o       (pix_x),
    .pix_y_o       (pix_y),
    .pix_data_o    (pix_data),
    .frame_start_o (frame_start),
    .locked_o      (locked),
    .meas_h_total_o(meas_h),
    .meas_v_total_o(meas_v)
  );

  always #5 clk = ~clk;

  int checks = 0, errors = 0;
  int tick_no = 0, last_rise_tick = 0, fall_lag = -1;
  logic [11:0] meas_at_fall = 12'd0;
  int vcount = 0, fscount = 0;
  logic prev_locked = 1'b0;
  // Pins driven one and two ticks ago, with the coordinate each pixel was generated for
  logic [23:0] hist_rgb0 = 24'd0, hist_rgb1 = 24'd0, rgb_pend = 24'd0;
  int hist_x0 = -1, hist_x1 = -1, hist_y0 = -1, hist_y1 = -1, pend_x = -1, pend_y = -1;
  int gh = 0, gv = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] pack565(input logic [23:0] c);
    return {c[23:19], c[15:10], c[7:3]};
  endfunction

  function automatic logic [23:0] ramp(input int x, input int y);
    logic [7:0] rr, gg, bb;
    rr = 8'(x << 5);
    gg = 8'(y << 6);
    bb = 8'((x ^ y) << 5);
    return {rr, gg, bb};
  endfunction

  task automatic monitor();
    if (pix_valid) begin
      vcount++;
      chk("pix_x", 32'(pix_x), hist_x1);
      chk("pix_y", 32'(pix_y), hist_y1);
      chk("pix_data_latency2", 32'(pix_data), 32'(pack565(hist_rgb1)));
    end else begin
      chk("idle_zero", {pix_x, pix_y, pix_data}, 32'd0);
    end
    if (frame_start) begin
      fscount++;
      chk("frame_start_origin", 32'(hist_x1 == 0 && hist_y1 == 0), 32'd1);
    end
    if (prev_locked && !locked) begin
      fall_lag     = tick_no - last_rise_tick;
      meas_at_fall = meas_h;
    end
    prev_locked = locked;
  endtask

  // Loopback generator: sync pins follow the counter, colour pins lag it by one clock
  task automatic tick(input bit stuck);
    @(posedge clk);
    #1;
    tick_no++;
    monitor();
    hist_rgb1 = hist_rgb0;
    hist_x1   = hist_x0;
    hist_y1   = hist_y0;
    {r, g, b} = stuck ? 24'd0 : rgb_pend;
    hist_rgb0 = {r, g, b};
    hist_x0   = stuck ? -1 : pend_x;
    hist_y0   = stuck ? -1 : pend_y;
    if (stuck) begin
      hsync    = 1'b0;
      rgb_pend = 24'd0;
      pend_x   = -1;
      pend_y   = -1;
    end else begin
      if (gh == 0) last_rise_tick = tick_no;
      hsync = (gh < HS);
      vsync = (gv < VS);
      if (gh >= HS + HB && gh < HS + HB + HV && gv >= VS + VB && gv < VS + VB + VV) begin
        pend_x   = gh - HS - HB;
        pend_y   = gv - VS - VB;
        rgb_pend = ramp(pend_x, pend_y);
      end else begin
        pend_x   = -1;
        pend_y   = -1;
        rgb_pend = 24'd0;
      end
    end
  endtask

  task automatic run_line(input int len, input int line);
    gv = line;
    for (int i = 0; i < len; i++) begin
      gh = i;
      tick(1'b0);
    end
  endtask

  task automatic run_frame(input int nlines, input int short_at);
    vcount  = 0;
    fscount = 0;
    for (int l = 0; l < nlines; l++) run_line((l == short_at) ? HT - 1 : HT, l);
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_pix_valid"}, 32'(pix_valid), 32'd0);
    chk({tag, "_pix_x"}, 32'(pix_x), 32'd0);
    chk({tag, "_pix_y"}, 32'(pix_y), 32'd0);
    chk({tag, "_pix_data"}, 32'(pix_data), 32'd0);
    chk({tag, "_frame_start"}, 32'(frame_start), 32'd0);
    chk({tag, "_locked"}, 32'(locked), 32'd0);
    chk({tag, "_meas_h"}, 32'(meas_h), 32'd0);
    chk({tag, "_meas_v"}, 32'(meas_v), 32'd0);
  endtask

  initial begin
    for (int i = 0; i < 3; i++) tick(1'b1);
    chk_all_zero("reset");
    rst = 1'b0;

    // Acquisition: frames 0 and 1 build up lock, locked from the start of frame 2
    run_frame(VT, -1);
    chk("f0_valid", vcount, 0);
    run_frame(VT, -1);
    chk("f1_valid", vcount, 0);
    chk("f1_end_unlocked", 32'(locked), 32'd0);
    run_frame(VT, -1);
    chk("f2_valid", vcount, 32);
    chk("f2_frame_start", fscount, 1);
    chk("f2_locked", 32'(locked), 32'd1);
    chk("meas_h_total", 32'(meas_h), 32'd16);
    chk("meas_v_total", 32'(meas_v), 32'd10);
    run_frame(VT, -1);
    chk("f3_valid", vcount, 32);
    chk("f3_frame_start", fscount, 1);

    // Short line while locked: immediate drop, relock after two good frames
    run_frame(VT, 1);
    chk("short_fall_lag", fall_lag, 2);
    chk("short_meas_h", 32'(meas_at_fall), 32'd15);
    chk("short_frame_valid", vcount, 0);
    chk("short_frame_fs", fscount, 0);
    run_frame(VT, -1);
    chk("short_f5_valid", vcount, 0);
    run_frame(VT, -1);
    chk("short_f6_valid", vcount, 0);
    run_frame(VT, -1);
    chk("short_relock_valid", vcount, 32);
    chk("short_relock_fs", fscount, 1);

    // Eleven-line frame: drop at the following vs_rise
    fall_lag = -1;
    run_frame(VT + 1, -1);
    chk("long_frame_valid", vcount, 32);
    run_frame(VT, -1);
    chk("long_fall_lag", fall_lag, 2);
    chk("long_meas_v", 32'(meas_v), 32'd11);
    chk("long_next_valid", vcount, 0);
    run_frame(VT, -1);
    run_frame(VT, -1);
    chk("long_relock_valid", vcount, 32);

    // hsync stuck low for 5000 clocks after line 0
    fall_lag = -1;
    vcount   = 0;
    fscount  = 0;
    run_line(HT, 0);
    for (int i = 0; i < 5000; i++) tick(1'b1);
    chk("stuck_lock_holds", 32'(locked), 32'd1);
    for (int l = 1; l < VT; l++) run_line(HT, l);
    chk("stuck_fall_lag", fall_lag, 2);
    chk("stuck_meas_h_wrap", 32'(meas_at_fall), 32'd0);
    chk("stuck_frame_valid", vcount, 0);
    run_frame(VT, -1);
    run_frame(VT, -1);
    chk("stuck_frame_was_bad", vcount, 0);
    run_frame(VT, -1);
    chk("stuck_relock_valid", vcount, 32);

    // Asynchronous reset in the middle of an active line
    for (int l = 0; l < 4; l++) run_line(HT, l);
    gv = 4;
    for (int i = 0; i < 10; i++) begin
      gh = i;
      tick(1'b0);
    end
    chk("pre_reset_valid", 32'(pix_valid), 32'd1);
    rst = 1'b1;
    #1;
    chk_all_zero("midline_reset");
    for (int i = 10; i < HT; i++) begin
      gh = i;
      tick(1'b0);
    end
    rst     = 1'b0;
    fscount = 0;
    for (int l = 5; l < VT; l++) run_line(HT, l);
    for (int f = 0; f < 2; f++) begin
      vcount = 0;
      for (int l = 0; l < VT; l++) run_line(HT, l);
      chk("post_reset_valid", vcount, 0);
    end
    chk("post_reset_no_fs", fscount, 0);
    run_frame(VT, -1);
    chk("post_reset_relock_valid", vcount, 32);
    chk("post_reset_relock_fs", fscount, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
